// File: rtl/spi_reg_responder.sv
// SPI responder decoding 16-bit frames (R/W, 7-bit address, 8-bit data) into
// single-cycle register strobes; read data is shifted back on sdo.
module spi_reg_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs,
  input  logic       sck,
  input  logic       sdi,
  output logic       sdo,
  output logic       sdo_oe,
  output logic [6:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic       frame_err
);

  typedef enum logic [1:0] {IDLE, HDR, RDCAP, DATA} state_t;

  logic [SYNC_STAGES-1:0] cs_sync, sck_sync, sdi_sync;
  logic cs_prev, sck_prev, sdi_prev;
  logic cs_fall_q, cs_rise_q, sck_rise_q, sck_fall_q;

  state_t     state, state_nxt;
  logic [4:0] bit_cnt, cnt_nxt;
  logic [7:0] shift_sr, shift_nxt;
  logic [7:0] tx_sr, tx_nxt;
  logic       rw, rw_nxt;
  logic [6:0] addr_nxt;
  logic [7:0] wdata_nxt;
  logic       we_nxt, re_nxt, err_nxt, sdo_nxt, oe_nxt;

  // Synchronizers reset to 0 so a cs held low across reset never looks like a new frame start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_sync    <= '0;
      sck_sync   <= '0;
      sdi_sync   <= '0;
      cs_prev    <= 1'b0;
      sck_prev   <= 1'b0;
      sdi_prev   <= 1'b0;
      cs_fall_q  <= 1'b0;
      cs_rise_q  <= 1'b0;
      sck_rise_q <= 1'b0;
      sck_fall_q <= 1'b0;
    end else begin
      cs_sync    <= {cs_sync[SYNC_STAGES-2:0], cs};
      sck_sync   <= {sck_sync[SYNC_STAGES-2:0], sck};
      sdi_sync   <= {sdi_sync[SYNC_STAGES-2:0], sdi};
      cs_prev    <= cs_sync[SYNC_STAGES-1];
      sck_prev   <= sck_sync[SYNC_STAGES-1];
      sdi_prev   <= sdi_sync[SYNC_STAGES-1];
      cs_fall_q  <= cs_prev & ~cs_sync[SYNC_STAGES-1];
      cs_rise_q  <= ~cs_prev & cs_sync[SYNC_STAGES-1];
      sck_rise_q <= ~sck_prev & sck_sync[SYNC_STAGES-1];
      sck_fall_q <= sck_prev & ~sck_sync[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift_sr  <= '0;
      tx_sr     <= '0;
      rw        <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      frame_err <= 1'b0;
      sdo       <= 1'b0;
      sdo_oe    <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= cnt_nxt;
      shift_sr  <= shift_nxt;
      tx_sr     <= tx_nxt;
      rw        <= rw_nxt;
      reg_addr  <= addr_nxt;
      reg_wdata <= wdata_nxt;
      reg_we    <= we_nxt;
      reg_re    <= re_nxt;
      frame_err <= err_nxt;
      sdo       <= sdo_nxt;
      sdo_oe    <= oe_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = bit_cnt;
    shift_nxt = shift_sr;
    tx_nxt    = tx_sr;
    rw_nxt    = rw;
    addr_nxt  = reg_addr;
    wdata_nxt = reg_wdata;
    we_nxt    = 1'b0;
    re_nxt    = 1'b0;
    err_nxt   = 1'b0;
    sdo_nxt   = sdo;
    oe_nxt    = sdo_oe;
    if (state != IDLE && cs_rise_q) begin
      state_nxt = IDLE;
      sdo_nxt   = 1'b0;
      oe_nxt    = 1'b0;
      if (bit_cnt == 5'd16) begin
        if (state == DATA && !rw) begin
          we_nxt    = 1'b1;
          wdata_nxt = shift_sr;
        end
      end else begin
        err_nxt = 1'b1;
      end
    end else begin
      case (state)
        IDLE: begin
          if (cs_fall_q) begin
            state_nxt = HDR;
            cnt_nxt   = '0;
            shift_nxt = '0;
            tx_nxt    = '0;
            rw_nxt    = 1'b0;
          end
        end
        HDR: begin
          if (sck_rise_q) begin
            shift_nxt = {shift_sr[6:0], sdi_prev};
            cnt_nxt   = bit_cnt + 5'd1;
            if (bit_cnt == 5'd7) begin
              rw_nxt   = shift_sr[6];
              addr_nxt = {shift_sr[5:0], sdi_prev};
              if (shift_sr[6]) begin
                re_nxt    = 1'b1;
                state_nxt = RDCAP;
              end else begin
                state_nxt = DATA;
              end
            end
          end
        end
        RDCAP: begin
          // Let the reg_re cycle pass; read data is valid in the cycle after it.
          if (!reg_re) begin
            tx_nxt    = reg_rdata;
            state_nxt = DATA;
          end
        end
        DATA: begin
          if (sck_rise_q) begin
            shift_nxt = {shift_sr[6:0], sdi_prev};
            if (bit_cnt != 5'd31) cnt_nxt = bit_cnt + 5'd1;
          end
          if (sck_fall_q && rw) begin
            sdo_nxt = tx_sr[7];
            tx_nxt  = {tx_sr[6:0], 1'b0};
            oe_nxt  = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_spi_reg_responder.sv
// Directed bench for spi_reg_responder: SPI master model plus pulse monitor.
module tb_spi_reg_responder;

  localparam int SYNC_STAGES = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cs = 1'b1;
  logic       sck = 1'b0;
  logic       sdi = 1'b0;
  logic       sdo, sdo_oe, reg_we, reg_re, busy, frame_err;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata = 8'h00;

  int checks = 0;
  int failures = 0;
  int we_cnt, re_cnt, err_cnt;
  logic [6:0] we_addr [0:3];
  logic [7:0] we_data [0:3];
  logic [6:0] re_addr;
  logic       oe_seen, sdo_bad;
  logic [7:0] rd_value = 8'h00;
  logic [7:0] rx;

  spi_reg_responder #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .rst(rst), .cs(cs), .sck(sck), .sdi(sdi),
    .sdo(sdo), .sdo_oe(sdo_oe), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata),
    .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Register bank model: read data valid only in the cycle after reg_re.
  always @(posedge clk) begin
    if (reg_re) begin
      #1 reg_rdata = rd_value;
    end else begin
      #1 reg_rdata = 8'h00;
    end
  end

  always @(negedge clk) begin
    if (reg_we) begin
      we_addr[we_cnt[1:0]] = reg_addr;
      we_data[we_cnt[1:0]] = reg_wdata;
      we_cnt++;
    end
    if (reg_re) begin
      re_cnt++;
      re_addr = reg_addr;
    end
    if (frame_err) err_cnt++;
    if (sdo_oe) oe_seen = 1'b1;
    if (sdo && !sdo_oe) sdo_bad = 1'b1;
  end

  task automatic clr();
    we_cnt = 0; re_cnt = 0; err_cnt = 0;
    oe_seen = 1'b0; sdo_bad = 1'b0; rx = 8'h00;
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One frame at a 32-clk sck period; rst_at>0 pulses reset right after that sck rise.
  task automatic frame(input logic [15:0] word, input int nbits, input int rst_at, input int gap);
    cs = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      sdi = (i < 16) ? word[4'(15 - i)] : 1'b0;
      wait_clk(16);
      if (i >= 8 && i < 16) rx = {rx[6:0], sdo};
      sck = 1'b1;
      if (i + 1 == rst_at) begin
        rst = 1'b1;
        wait_clk(3);
        rst = 1'b0;
      end
      wait_clk(16);
      sck = 1'b0;
    end
    wait_clk(16);
    cs = 1'b1;
    wait_clk(gap);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wait_clk(5);
    checks++; if (sdo !== 1'b0) begin failures++; $display("FAIL reset_sdo got=%b exp=0", sdo); end
    checks++; if (sdo_oe !== 1'b0) begin failures++; $display("FAIL reset_sdo_oe got=%b exp=0", sdo_oe); end
    checks++; if (reg_addr !== 7'h00) begin failures++; $display("FAIL reset_addr got=%h exp=00", reg_addr); end
    checks++; if (reg_wdata !== 8'h00) begin failures++; $display("FAIL reset_wdata got=%h exp=00", reg_wdata); end
    checks++; if ({reg_we, reg_re, frame_err} !== 3'b000) begin failures++; $display("FAIL reset_strobes got=%b exp=000", {reg_we, reg_re, frame_err}); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst = 1'b0;
    wait_clk(10);
  endtask

  task automatic test_write();
    clr();
    frame(16'h12A5, 16, 0, 40);
    checks++; if (we_cnt !== 1) begin failures++; $display("FAIL write_we_count got=%0d exp=1", we_cnt); end
    checks++; if (we_addr[0] !== 7'h12) begin failures++; $display("FAIL write_addr got=%h exp=12", we_addr[0]); end
    checks++; if (we_data[0] !== 8'hA5) begin failures++; $display("FAIL write_data got=%h exp=a5", we_data[0]); end
    checks++; if (err_cnt !== 0) begin failures++; $display("FAIL write_frame_err got=%0d exp=0", err_cnt); end
    checks++; if (oe_seen !== 1'b0) begin failures++; $display("FAIL write_sdo_oe got=%b exp=0", oe_seen); end
    checks++; if (re_cnt !== 0) begin failures++; $display("FAIL write_re_count got=%0d exp=0", re_cnt); end
  endtask

  task automatic test_read();
    clr();
    rd_value = 8'h5A;
    frame(16'hB4C0, 16, 0, 40);
    checks++; if (re_cnt !== 1) begin failures++; $display("FAIL read_re_count got=%0d exp=1", re_cnt); end
    checks++; if (re_addr !== 7'h34) begin failures++; $display("FAIL read_addr got=%h exp=34", re_addr); end
    checks++; if (rx !== 8'h5A) begin failures++; $display("FAIL read_sdo_data got=%h exp=5a", rx); end
    checks++; if (we_cnt !== 0) begin failures++; $display("FAIL read_we_count got=%0d exp=0", we_cnt); end
    checks++; if (err_cnt !== 0) begin failures++; $display("FAIL read_frame_err got=%0d exp=0", err_cnt); end
    checks++; if (oe_seen !== 1'b1) begin failures++; $display("FAIL read_sdo_oe got=%b exp=1", oe_seen); end
    checks++; if (sdo_bad !== 1'b0) begin failures++; $display("FAIL read_sdo_without_oe got=%b exp=0", sdo_bad); end
    checks++; if ({sdo_oe, sdo} !== 2'b00) begin failures++; $display("FAIL read_sdo_idle got=%b exp=00", {sdo_oe, sdo}); end
  endtask

  task automatic test_short();
    clr();
    frame(16'h12A5, 10, 0, 40);
    checks++; if (err_cnt !== 1) begin failures++; $display("FAIL short_frame_err got=%0d exp=1", err_cnt); end
    checks++; if (we_cnt !== 0) begin failures++; $display("FAIL short_we_count got=%0d exp=0", we_cnt); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL short_busy got=%b exp=0", busy); end
  endtask

  task automatic test_long();
    clr();
    frame(16'h0BEE, 17, 0, 40);
    checks++; if (err_cnt !== 1) begin failures++; $display("FAIL long_frame_err got=%0d exp=1", err_cnt); end
    checks++; if (we_cnt !== 0) begin failures++; $display("FAIL long_we_count got=%0d exp=0", we_cnt); end
    clr();
    frame(16'h053C, 16, 0, 40);
    checks++; if (we_cnt !== 1) begin failures++; $display("FAIL long_next_we_count got=%0d exp=1", we_cnt); end
    checks++; if ({we_addr[0], we_data[0]} !== {7'h05, 8'h3C}) begin failures++; $display("FAIL long_next_addr_data got=%h/%h exp=05/3c", we_addr[0], we_data[0]); end
    checks++; if (err_cnt !== 0) begin failures++; $display("FAIL long_next_frame_err got=%0d exp=0", err_cnt); end
  endtask

  task automatic test_reset_midframe();
    clr();
    frame(16'h7F11, 16, 12, 40);
    checks++; if ({we_cnt, re_cnt, err_cnt} !== {32'd0, 32'd0, 32'd0}) begin failures++; $display("FAIL midreset_strobes got=we%0d re%0d err%0d exp=0/0/0", we_cnt, re_cnt, err_cnt); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midreset_busy got=%b exp=0", busy); end
    clr();
    frame(16'h2266, 16, 0, 40);
    checks++; if (we_cnt !== 1) begin failures++; $display("FAIL midreset_next_we_count got=%0d exp=1", we_cnt); end
    checks++; if ({we_addr[0], we_data[0]} !== {7'h22, 8'h66}) begin failures++; $display("FAIL midreset_next_addr_data got=%h/%h exp=22/66", we_addr[0], we_data[0]); end
  endtask

  task automatic test_back_to_back();
    clr();
    frame(16'h4181, 16, 0, SYNC_STAGES + 2);
    frame(16'h7E18, 16, 0, 40);
    checks++; if (we_cnt !== 2) begin failures++; $display("FAIL b2b_we_count got=%0d exp=2", we_cnt); end
    checks++; if ({we_addr[0], we_data[0]} !== {7'h41, 8'h81}) begin failures++; $display("FAIL b2b_first got=%h/%h exp=41/81", we_addr[0], we_data[0]); end
    checks++; if ({we_addr[1], we_data[1]} !== {7'h7E, 8'h18}) begin failures++; $display("FAIL b2b_second got=%h/%h exp=7e/18", we_addr[1], we_data[1]); end
    checks++; if (err_cnt !== 0) begin failures++; $display("FAIL b2b_frame_err got=%0d exp=0", err_cnt); end
  endtask

  initial begin
    clr();
    test_reset();
    test_write();
    test_read();
    test_short();
    test_long();
    test_reset_midframe();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
